pid_uk_accum: RTL and testbench

PID_UK_ACCUM -- requirements
Module: pid_uk_accum

---
 rtl/pid_pkg.sv | 23 ++
 rtl/pid_pwm.sv | 53 +++++
 rtl/pid_uk_accum.sv | 121 ++++++++++++
 tb/tb_pid_uk_accum.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pid_pkg
//  Brief    : Shared types and constants for the PID u(k) accumulator slice.
//  Revision : 1.0  initial release
// ============================================================================
package pid_pkg;

  // Accumulator FSM states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pid_state_t;

  // Width of the signed increment coming from the increment stage
  localparam int D_UK_W = 15;

  // Default output width and upper clamp
  localparam int UK_W_DEF   = 12;
  localparam int UK_MAX_DEF = 4095;

endpackage : pid_pkg
`default_nettype wire

// File: rtl/pid_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : pid_pwm
//  Brief    : Free-running PWM generator. Duty is latched only at the period
//             wrap so a mid-period change never produces a glitched pulse.
//  Revision : 1.0  initial release
// ============================================================================
module pid_pwm
  import pid_pkg::*;
#(
  parameter int UK_W    = UK_W_DEF,
  parameter int UK_INIT = 0,
  parameter int UK_MAX  = UK_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [UK_W-1:0] duty_in,
  output logic            pwm_out
);

  localparam logic [UK_W-1:0] C_CNT_MAX = UK_W'(UK_MAX);
  localparam logic [UK_W-1:0] C_INIT    = UK_W'(UK_INIT);

  logic [UK_W-1:0] r_cnt;
  logic [UK_W-1:0] r_duty;
  logic            w_wrap;

  assign w_wrap = (r_cnt == C_CNT_MAX);

  // Period counter and duty latch; duty refreshes as the counter returns to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_duty <= C_INIT;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_duty <= duty_in;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Registered compare keeps the output free of combinational glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (r_cnt < r_duty);
    end
  end

endmodule : pid_pwm
`default_nettype wire

// File: rtl/pid_uk_accum.sv
`default_nettype none
// ============================================================================
//  Module   : pid_uk_accum
//  Brief    : Accumulates signed PID increments into a clamped unsigned u(k)
//             with anti-windup saturation flags. Optional PWM output is
//             compiled in when the macro PID_PWM_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module pid_uk_accum
  import pid_pkg::*;
#(
  parameter int UK_W    = UK_W_DEF,
  parameter int UK_INIT = 0,
  parameter int UK_MAX  = UK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [D_UK_W-1:0] d_uk,
  input  logic              d_valid,
  output logic [UK_W-1:0]   uk,
  output logic              uk_valid,
  output logic              sat_hi,
  output logic              sat_lo
`ifdef PID_PWM_EN
  ,
  output logic              pwm_out
`endif
);

  // Two guard bits over the wider operand so the sum can never overflow
  localparam int SUM_W = ((UK_W > D_UK_W) ? UK_W : D_UK_W) + 2;

  localparam logic signed [SUM_W-1:0] C_SUM_MAX = SUM_W'(UK_MAX);
  localparam logic [UK_W-1:0]         C_UK_MAX  = UK_W'(UK_MAX);
  localparam logic [UK_W-1:0]         C_UK_INIT = UK_W'(UK_INIT);

  pid_state_t               r_state;
  pid_state_t               w_state_nxt;
  logic signed [SUM_W-1:0]  w_sum;
  logic                     w_accept;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state follows en; acceptance depends only on the current state
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) w_state_nxt = RUN;
      end
      RUN: begin
        w_accept = d_valid;
        if (!en) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Zero-extended u(k) plus sign-extended increment
  always_comb begin
    w_sum = $signed({{(SUM_W-UK_W){1'b0}}, uk}) +
            $signed({{(SUM_W-D_UK_W){d_uk[D_UK_W-1]}}, d_uk});
  end

  // Accumulator with clamping; the clamped value is what feeds back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uk       <= C_UK_INIT;
      uk_valid <= 1'b0;
      sat_hi   <= 1'b0;
      sat_lo   <= 1'b0;
    end else if (clr) begin
      uk       <= C_UK_INIT;
      uk_valid <= 1'b0;
      sat_hi   <= 1'b0;
      sat_lo   <= 1'b0;
    end else if (w_accept) begin
      uk_valid <= 1'b1;
      if (w_sum < 0) begin
        uk     <= '0;
        sat_lo <= 1'b1;
        sat_hi <= 1'b0;
      end else if (w_sum > C_SUM_MAX) begin
        uk     <= C_UK_MAX;
        sat_hi <= 1'b1;
        sat_lo <= 1'b0;
      end else begin
        uk     <= w_sum[UK_W-1:0];
        sat_hi <= 1'b0;
        sat_lo <= 1'b0;
      end
    end else begin
      uk_valid <= 1'b0;
    end
  end

`ifdef PID_PWM_EN
  pid_pwm #(
    .UK_W    (UK_W),
    .UK_INIT (UK_INIT),
    .UK_MAX  (UK_MAX)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .duty_in (uk),
    .pwm_out (pwm_out)
  );
`endif

endmodule : pid_uk_accum
`default_nettype wire

// File: tb/tb_pid_uk_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pid_uk_accum
//  Brief    : Directed self-checking bench for pid_uk_accum (default params).
//             PWM checks are compiled when PID_PWM_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pid_uk_accum;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [14:0] d_uk;
  logic        d_valid;
  logic [11:0] uk;
  logic        uk_valid;
  logic        sat_hi;
  logic        sat_lo;
`ifdef PID_PWM_EN
  logic        pwm_out;
`endif

  int errors = 0;
  int checks = 0;

  pid_uk_accum dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .d_uk     (d_uk),
    .d_valid  (d_valid),
    .uk       (uk),
    .uk_valid (uk_valid),
    .sat_hi   (sat_hi),
    .sat_lo   (sat_lo)
`ifdef PID_PWM_EN
    ,
    .pwm_out  (pwm_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then sample 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check uk, uk_valid, sat_hi, sat_lo together
  task automatic check_out(input string tag, input int e_uk, input logic e_v,
                           input logic e_hi, input logic e_lo);
    check({tag, ".uk"},       32'(uk),       32'(e_uk));
    check({tag, ".uk_valid"}, 32'(uk_valid), 32'(e_v));
    check({tag, ".sat_hi"},   32'(sat_hi),   32'(e_hi));
    check({tag, ".sat_lo"},   32'(sat_lo),   32'(e_lo));
  endtask

  task automatic drive(input logic v, input int inc);
    d_valid = v;
    d_uk    = 15'(inc);
  endtask

  initial begin
`ifdef PID_PWM_EN
    int hi_cnt;
    int wait_cnt;
`endif
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; d_uk = '0; d_valid = 1'b0;
    #1;
    check_out("reset", 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // IDLE -> RUN; a strobe while still IDLE is ignored
    en = 1'b1; drive(1'b1, 9);
    step();
    check_out("idle_ignore", 0, 1'b0, 1'b0, 1'b0);

    // Back-to-back +100 increments
    drive(1'b1, 100);
    step(); check_out("acc100", 100, 1'b1, 1'b0, 1'b0);
    step(); check_out("acc200", 200, 1'b1, 1'b0, 1'b0);
    step(); check_out("acc300", 300, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 0);
    step(); check_out("hold300", 300, 1'b0, 1'b0, 1'b0);

    // Upper clamp and anti-windup
    drive(1'b1, 3700);
    step(); check_out("to4000", 4000, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 200);
    step(); check_out("sat_hi", 4095, 1'b1, 1'b1, 1'b0);
    drive(1'b1, -10);
    step(); check_out("unwind_hi", 4085, 1'b1, 1'b0, 1'b0);

    // Lower clamp with the most negative increment
    drive(1'b1, -4035);
    step(); check_out("to50", 50, 1'b1, 1'b0, 1'b0);
    drive(1'b1, -16384);
    step(); check_out("sat_lo", 0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 5);
    step(); check_out("unwind_lo", 5, 1'b1, 1'b0, 1'b0);

    // en falls with a strobe: still accepted, the next strobe is not
    en = 1'b0; drive(1'b1, 7);
    step(); check_out("en_fall", 12, 1'b1, 1'b0, 1'b0);
    step(); check_out("en_low", 12, 1'b0, 1'b0, 1'b0);

    // Back to RUN, saturate low, then clr beats a same-cycle strobe
    en = 1'b1; drive(1'b0, 0);
    step();
    drive(1'b1, -100);
    step(); check_out("pre_clr", 0, 1'b1, 1'b0, 1'b1);
    clr = 1'b1; drive(1'b1, 7);
    step(); check_out("clr", 0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0; drive(1'b1, 1234);
    step(); check_out("after_clr", 1234, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with a pending increment
    drive(1'b1, 5);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 0, 1'b0, 1'b0, 1'b0);
    step();
    #2 rst_n = 1'b1;
    step(); check_out("post_rst", 0, 1'b0, 1'b0, 1'b0);
    step(); check_out("post_rst_run", 5, 1'b1, 1'b0, 1'b0);

`ifdef PID_PWM_EN
    // Bring uk to 1024 and let the duty latch settle
    drive(1'b1, 1019);
    step(); check_out("uk1024", 1024, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 0);
    repeat (4100) step();
    // Align to period start: first high sample after a low one
    wait_cnt = 0;
    while (pwm_out !== 1'b1 && wait_cnt < 5000) begin step(); wait_cnt++; end
    while (pwm_out !== 1'b0 && wait_cnt < 10000) begin step(); wait_cnt++; end
    while (pwm_out !== 1'b1 && wait_cnt < 15000) begin step(); wait_cnt++; end
    check("pwm_align_timeout", 32'(wait_cnt < 15000), 32'd1);
    // Period with a mid-period uk change that must not take effect yet
    hi_cnt = 32'(pwm_out);
    for (int i = 1; i < 4096; i++) begin
      step();
      hi_cnt += 32'(pwm_out);
      if (i == 2000) drive(1'b1, 1024);
      if (i == 2001) drive(1'b0, 0);
    end
    check("pwm_duty1024", 32'(hi_cnt), 32'd1024);
    check("uk2048", 32'(uk), 32'd2048);
    hi_cnt = 0;
    for (int i = 0; i < 4096; i++) begin
      step();
      hi_cnt += 32'(pwm_out);
    end
    check("pwm_duty2048", 32'(hi_cnt), 32'd2048);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pid_uk_accum
`default_nettype wire
